// File: rtl/vga_sync_gen.sv
// Raster timing source: beam counters, sync decode and a registered 3-bit-per-channel VGA output stage.
// Define VGA_SYNC_GEN_PIXEL_DIV2_EN to run one pixel every two clocks via an internal pixel enable.
module vga_sync_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_visible,
    output logic       o_line_start,
    output logic       o_frame_start,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic       o_vga_hsync,
    output logic       o_vga_vsync,
    output logic [2:0] o_vga_r,
    output logic [2:0] o_vga_g,
    output logic [2:0] o_vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       hsync_q, hsync_d, hsync_s;
    logic       vsync_q, vsync_d, vsync_s;
    logic [2:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       visible_s;
    logic       pix_tick_s;

`ifdef VGA_SYNC_GEN_PIXEL_DIV2_EN
    logic pix_en_q;

    // Pixel enable alternates every clock so each pixel spans two clocks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
        end
    end

    assign pix_tick_s = pix_en_q;
`else
    assign pix_tick_s = 1'b1;
`endif

    assign visible_s     = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign o_hpos        = hcount_q;
    assign o_vpos        = vcount_q;
    assign o_visible     = visible_s;
    assign o_line_start  = (hcount_q == 10'd0);
    assign o_frame_start = (hcount_q == 10'd0) && (vcount_q == 10'd0);

    // Beam counters: vcount steps only on the hcount wrap, both wrap on the same tick.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_tick_s) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d = 10'd0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end else begin
            hcount_d = hcount_q;
        end
    end

    // Sync windows decoded from the current beam position.
    always_comb begin
        hsync_s = ~SYNC_ACTIVE;
        vsync_s = ~SYNC_ACTIVE;
        if ((hcount_q >= HS_LO) && (hcount_q < HS_HI)) begin
            hsync_s = SYNC_ACTIVE;
        end else begin
            hsync_s = ~SYNC_ACTIVE;
        end
        if ((vcount_q >= VS_LO) && (vcount_q < VS_HI)) begin
            vsync_s = SYNC_ACTIVE;
        end else begin
            vsync_s = ~SYNC_ACTIVE;
        end
    end

    // Output stage next state: colour is forced black outside the active area.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        if (pix_tick_s) begin
            hsync_d = hsync_s;
            vsync_d = vsync_s;
            if (visible_s) begin
                r_d = i_r[7:5];
                g_d = i_g[7:5];
                b_d = i_b[7:5];
            end else begin
                r_d = 3'b000;
                g_d = 3'b000;
                b_d = 3'b000;
            end
        end else begin
            hsync_d = hsync_q;
        end
    end

    // Counter and output-stage registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            r_q      <= 3'b000;
            g_q      <= 3'b000;
            b_q      <= 3'b000;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign o_vga_hsync = hsync_q;
    assign o_vga_vsync = vsync_q;
    assign o_vga_r     = r_q;
    assign o_vga_g     = g_q;
    assign o_vga_b     = b_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised bench for vga_sync_gen: a shrunk-raster instance (active-low sync) and a default-raster
// instance (active-high sync) checked every clock against a pixel-tick-count reference model.
module tb_vga_sync_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int DHT = 800, DVT = 525;
`ifdef VGA_SYNC_GEN_PIXEL_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r_s = 8'd0, g_s = 8'd0, b_s = 8'd0;

    logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
    logic       a_vis, a_ls, a_fs, a_hs, a_vs, b_vis, b_ls, b_fs, b_hs, b_vs;
    logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b;

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0)
    ) dut_a (
        .i_clk(clk), .i_reset(rst),
        .o_hpos(a_hpos), .o_vpos(a_vpos), .o_visible(a_vis),
        .o_line_start(a_ls), .o_frame_start(a_fs),
        .i_r(r_s), .i_g(g_s), .i_b(b_s),
        .o_vga_hsync(a_hs), .o_vga_vsync(a_vs),
        .o_vga_r(a_r), .o_vga_g(a_g), .o_vga_b(a_b)
    );

    vga_sync_gen #(
        .SYNC_ACTIVE(1'b1)
    ) dut_b (
        .i_clk(clk), .i_reset(rst),
        .o_hpos(b_hpos), .o_vpos(b_vpos), .o_visible(b_vis),
        .o_line_start(b_ls), .o_frame_start(b_fs),
        .i_r(r_s), .i_g(g_s), .i_b(b_s),
        .o_vga_hsync(b_hs), .o_vga_vsync(b_vs),
        .o_vga_r(b_r), .o_vga_g(b_g), .o_vga_b(b_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pixel ticks since reset release plus the expected output-stage contents.
    int         t;
    bit         en_m;
    logic       ehs_a, evs_a, ehs_b, evs_b;
    logic [2:0] er_a, eg_a, eb_a, er_b, eg_b, eb_b;

    int clk_i, last_ls, last_fs, hs_run;
    bit prev_ls, prev_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic bit in_win(input int p, input int lo, input int w);
        return (p >= lo) && (p < lo + w);
    endfunction

    task automatic model_reset();
        t = 0; en_m = 1'b0;
        ehs_a = 1'b1; evs_a = 1'b1; ehs_b = 1'b0; evs_b = 1'b0;
        er_a = 3'd0; eg_a = 3'd0; eb_a = 3'd0;
        er_b = 3'd0; eg_b = 3'd0; eb_b = 3'd0;
        last_ls = -1; last_fs = -1; prev_ls = 1'b0; prev_fs = 1'b0; hs_run = 0;
    endtask

    task automatic model_edge();
        int ha, va, hb, vb;
        bit visa, visb;
        if (DIV == 1 || en_m) begin
            ha = t % HT;  va = (t / HT) % VT;
            hb = t % DHT; vb = (t / DHT) % DVT;
            visa = (ha < HV) && (va < VV);
            visb = (hb < 640) && (vb < 480);
            ehs_a = in_win(ha, HV + HF, HS) ? 1'b0 : 1'b1;
            evs_a = in_win(va, VV + VF, VS) ? 1'b0 : 1'b1;
            ehs_b = in_win(hb, 656, 96) ? 1'b1 : 1'b0;
            evs_b = in_win(vb, 490, 2) ? 1'b1 : 1'b0;
            er_a = visa ? r_s[7:5] : 3'd0; eg_a = visa ? g_s[7:5] : 3'd0; eb_a = visa ? b_s[7:5] : 3'd0;
            er_b = visb ? r_s[7:5] : 3'd0; eg_b = visb ? g_s[7:5] : 3'd0; eb_b = visb ? b_s[7:5] : 3'd0;
            t++;
        end
        if (DIV == 2) en_m = !en_m;
    endtask

    task automatic check_all();
        int ha, va, hb, vb;
        ha = t % HT;  va = (t / HT) % VT;
        hb = t % DHT; vb = (t / DHT) % DVT;
        check("a_hpos", 32'(a_hpos), 32'(ha));
        check("a_vpos", 32'(a_vpos), 32'(va));
        check("a_visible", 32'(a_vis), 32'(ha < HV && va < VV));
        check("a_line_start", 32'(a_ls), 32'(ha == 0));
        check("a_frame_start", 32'(a_fs), 32'(ha == 0 && va == 0));
        check("a_hsync", 32'(a_hs), 32'(ehs_a));
        check("a_vsync", 32'(a_vs), 32'(evs_a));
        check("a_rgb", 32'({a_r, a_g, a_b}), 32'({er_a, eg_a, eb_a}));
        check("b_hpos", 32'(b_hpos), 32'(hb));
        check("b_vpos", 32'(b_vpos), 32'(vb));
        check("b_visible", 32'(b_vis), 32'(hb < 640 && vb < 480));
        check("b_hsync", 32'(b_hs), 32'(ehs_b));
        check("b_vsync", 32'(b_vs), 32'(evs_b));
        check("b_rgb", 32'({b_r, b_g, b_b}), 32'({er_b, eg_b, eb_b}));
    endtask

    // Independent period and pulse-width measurements in clocks.
    task automatic measure();
        if (a_ls && !prev_ls) begin
            if (last_ls >= 0) check("line_period", 32'(clk_i - last_ls), 32'(HT * DIV));
            last_ls = clk_i;
        end
        if (a_fs && !prev_fs) begin
            if (last_fs >= 0) check("frame_period", 32'(clk_i - last_fs), 32'(HT * VT * DIV));
            last_fs = clk_i;
        end
        prev_ls = a_ls; prev_fs = a_fs;
        if (b_hs) begin
            hs_run++;
        end else if (hs_run > 0) begin
            check("hsync_width", 32'(hs_run), 32'(96 * DIV));
            hs_run = 0;
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                1: begin r_s = 8'hFF; g_s = 8'hFF; b_s = 8'hFF; end
                2: begin r_s = 8'hA5; g_s = 8'($urandom); b_s = 8'($urandom); end
                default: begin r_s = 8'($urandom); g_s = 8'($urandom); b_s = 8'($urandom); end
            endcase
            @(posedge clk);
            model_edge();
            @(negedge clk);
            clk_i++;
            check_all();
            measure();
        end
    endtask

    initial begin
        clk_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        run(1500, 0);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;

        run(1200, 1);
        run(600, 2);
        run(1500, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
